// File: rtl/uart_frame_parser_pkg.sv
// Shared types and default framing bytes for the UART frame parser.
package uart_frame_parser_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_CMD,
    S_PAY,
    S_END
  } parser_state_e;

  typedef enum logic [2:0] {
    E_NONE = 3'd0,
    E_LEN  = 3'd1,
    E_CMD  = 3'd2,
    E_END  = 3'd3,
    E_TMO  = 3'd4,
    E_OVR  = 3'd5
  } parser_err_e;

  localparam logic [7:0] DefStartByte = 8'hFE;
  localparam logic [7:0] DefEndByte   = 8'hEF;

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte idle counter; expired fires on the cycle the count would reach TIMEOUT_CYC.
module uart_frame_timeout #(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  if (TIMEOUT_CYC == 0) begin : g_off
    logic unused;
    assign unused  = clk ^ rst ^ clear ^ run;
    assign expired = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (cnt_q != CW'(TIMEOUT_CYC)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // A byte on the same cycle (clear) wins over expiry.
    assign expired = run && !clear && (cnt_q == CW'(TIMEOUT_CYC - 1));
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Decodes START, LEN, CMD, PAYLOAD, END frames from the UART byte stream and
// presents each complete frame on a valid/ready port with error reporting.
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter logic [7:0]  START_BYTE  = DefStartByte,
  parameter logic [7:0]  END_BYTE    = DefEndByte,
  parameter int unsigned MAX_PAYLOAD = 8,
  parameter int unsigned CMD_MAX     = 7,
  parameter int unsigned TIMEOUT_CYC = 100000,
  localparam int unsigned LW = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               UART_Rx,
  input  logic                     Flag_Rx,
  input  logic                     frame_ready,
  output logic                     frame_valid,
  output logic [7:0]               frame_cmd,
  output logic [LW-1:0]            frame_len,
  output logic [MAX_PAYLOAD*8-1:0] frame_payload,
  output logic                     err_pulse,
  output logic [2:0]               err_code,
  output logic                     busy
);

  localparam int unsigned IW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  parser_state_e state_q, state_d;
  parser_err_e   err_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [7:0]    cmd_q, cmd_d;

  logic [MAX_PAYLOAD-1:0][7:0] buf_q, buf_d;
  logic [MAX_PAYLOAD-1:0][7:0] opay_q, opay_d;

  logic          ovalid_q, ovalid_d;
  logic [7:0]    ocmd_q, ocmd_d;
  logic [LW-1:0] olen_q, olen_d;
  logic          err_pulse_q;
  logic [2:0]    err_code_q;
  logic          busy_q;

  logic tmo_expired;
  logic len_ok, cmd_ok;

  uart_frame_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (Flag_Rx || (state_q == S_IDLE)),
    .run    (state_q != S_IDLE),
    .expired(tmo_expired)
  );

  // LEN covers CMD + payload + END, so payload count is LEN-2.
  assign len_ok = (UART_Rx >= 8'd2) && (32'(UART_Rx) <= MAX_PAYLOAD + 32'd2);
  assign cmd_ok = (UART_Rx != 8'd0) && (32'(UART_Rx) <= CMD_MAX);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    cmd_d    = cmd_q;
    buf_d    = buf_q;
    ovalid_d = ovalid_q && !frame_ready;
    ocmd_d   = ocmd_q;
    olen_d   = olen_q;
    opay_d   = opay_q;
    err_d    = E_NONE;

    if (Flag_Rx) begin
      unique case (state_q)
        S_IDLE: begin
          if (UART_Rx == START_BYTE) begin
            state_d = S_LEN;
            buf_d   = '0;
          end
        end
        S_LEN: begin
          if (len_ok) begin
            len_d   = LW'(UART_Rx - 8'd2);
            state_d = S_CMD;
          end else begin
            err_d   = E_LEN;
            state_d = S_IDLE;
          end
        end
        S_CMD: begin
          if (cmd_ok) begin
            cmd_d   = UART_Rx;
            idx_d   = '0;
            state_d = (len_q != '0) ? S_PAY : S_END;
          end else begin
            err_d   = E_CMD;
            state_d = S_IDLE;
          end
        end
        S_PAY: begin
          buf_d[idx_q[IW-1:0]] = UART_Rx;
          idx_d = idx_q + LW'(1);
          if (idx_q + LW'(1) == len_q) begin
            state_d = S_END;
          end
        end
        S_END: begin
          if (UART_Rx == END_BYTE) begin
            state_d = S_IDLE;
            // Old frame still un-accepted this cycle: drop the new one.
            if (ovalid_q && !frame_ready) begin
              err_d = E_OVR;
            end else begin
              ovalid_d = 1'b1;
              ocmd_d   = cmd_q;
              olen_d   = len_q;
              opay_d   = buf_q;
            end
          end else begin
            err_d = E_END;
            if (UART_Rx == START_BYTE) begin
              state_d = S_LEN;
              buf_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (tmo_expired) begin
      err_d   = E_TMO;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      cmd_q       <= '0;
      buf_q       <= '0;
      ovalid_q    <= 1'b0;
      ocmd_q      <= '0;
      olen_q      <= '0;
      opay_q      <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= 3'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      cmd_q       <= cmd_d;
      buf_q       <= buf_d;
      ovalid_q    <= ovalid_d;
      ocmd_q      <= ocmd_d;
      olen_q      <= olen_d;
      opay_q      <= opay_d;
      err_pulse_q <= (err_d != E_NONE);
      if (err_d != E_NONE) begin
        err_code_q <= err_d;
      end
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign frame_valid   = ovalid_q;
  assign frame_cmd     = ocmd_q;
  assign frame_len     = olen_q;
  assign frame_payload = opay_q;
  assign err_pulse     = err_pulse_q;
  assign err_code      = err_code_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed self-checking bench for uart_frame_parser (MAX_PAYLOAD=8, TIMEOUT_CYC=50).
module tb_uart_frame_parser;

  localparam int unsigned MaxPayload = 8;
  localparam int unsigned TimeoutCyc = 50;
  localparam int unsigned LW = $clog2(MaxPayload + 1);

  logic                    clk;
  logic                    rst;
  logic [7:0]              UART_Rx;
  logic                    Flag_Rx;
  logic                    frame_ready;
  logic                    frame_valid;
  logic [7:0]              frame_cmd;
  logic [LW-1:0]           frame_len;
  logic [MaxPayload*8-1:0] frame_payload;
  logic                    err_pulse;
  logic [2:0]              err_code;
  logic                    busy;

  int passed = 0;
  int total  = 0;
  int err_seen = 0;

  uart_frame_parser #(
    .START_BYTE (8'hFE),
    .END_BYTE   (8'hEF),
    .MAX_PAYLOAD(MaxPayload),
    .CMD_MAX    (7),
    .TIMEOUT_CYC(TimeoutCyc)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .UART_Rx      (UART_Rx),
    .Flag_Rx      (Flag_Rx),
    .frame_ready  (frame_ready),
    .frame_valid  (frame_valid),
    .frame_cmd    (frame_cmd),
    .frame_len    (frame_len),
    .frame_payload(frame_payload),
    .err_pulse    (err_pulse),
    .err_code     (err_code),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (err_pulse) err_seen++;

  // Byte is sampled on the posedge in between; returns at the following negedge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    UART_Rx = b;
    Flag_Rx = 1'b1;
    @(negedge clk);
    Flag_Rx = 1'b0;
    UART_Rx = 8'h00;
  endtask

  task automatic test_reset;
    rst = 1'b0; Flag_Rx = 1'b0; UART_Rx = 8'h00; frame_ready = 1'b1;
    #12;
    total++; if ({frame_valid, err_pulse, busy} !== 3'b000) $display("FAIL reset_flags got %b want 000", {frame_valid, err_pulse, busy}); else passed++;
    total++; if ({frame_cmd, frame_len, err_code} !== '0) $display("FAIL reset_fields got %h/%h/%h want 0", frame_cmd, frame_len, err_code); else passed++;
    total++; if (frame_payload !== 64'h0) $display("FAIL reset_payload got %h want 0", frame_payload); else passed++;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_basic;
    int e0;
    logic [2:0] bz;
    e0 = err_seen;
    send(8'hFE); bz[0] = busy;
    send(8'h02); bz[1] = busy;
    send(8'h03); bz[2] = busy;
    total++; if (bz !== 3'b111) $display("FAIL basic_busy got %b want 111", bz); else passed++;
    send(8'hEF);
    total++; if (frame_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", frame_valid); else passed++;
    total++; if (frame_cmd !== 8'h03) $display("FAIL basic_cmd got %h want 03", frame_cmd); else passed++;
    total++; if (frame_len !== 4'd0) $display("FAIL basic_len got %0d want 0", frame_len); else passed++;
    total++; if (frame_payload !== 64'h0) $display("FAIL basic_payload got %h want 0", frame_payload); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL basic_busy_end got %b want 0", busy); else passed++;
    @(negedge clk);
    total++; if (frame_valid !== 1'b0) $display("FAIL basic_valid_clear got %b want 0", frame_valid); else passed++;
    @(negedge clk);
    total++; if (err_seen !== e0) $display("FAIL basic_no_err got %0d want %0d", err_seen, e0); else passed++;
  endtask

  task automatic test_payload;
    send(8'hFE); send(8'h05); send(8'h02); send(8'hAA); send(8'hFE); send(8'h55); send(8'hEF);
    total++; if (frame_valid !== 1'b1) $display("FAIL pay_valid got %b want 1", frame_valid); else passed++;
    total++; if (frame_cmd !== 8'h02) $display("FAIL pay_cmd got %h want 02", frame_cmd); else passed++;
    total++; if (frame_len !== 4'd3) $display("FAIL pay_len got %0d want 3", frame_len); else passed++;
    total++; if (frame_payload !== 64'h0000_0000_0055_FEAA) $display("FAIL pay_data got %h want 55FEAA", frame_payload); else passed++;
    // Full-size frame: LEN = MAX_PAYLOAD + 2 is the largest legal value.
    send(8'hFE); send(8'h0A); send(8'h07);
    for (int i = 1; i <= 8; i++) send(8'(i));
    send(8'hEF);
    total++; if ({frame_valid, frame_cmd, frame_len} !== {1'b1, 8'h07, 4'd8}) $display("FAIL max_hdr got %b/%h/%0d want 1/07/8", frame_valid, frame_cmd, frame_len); else passed++;
    total++; if (frame_payload !== 64'h0807_0605_0403_0201) $display("FAIL max_data got %h want 0807060504030201", frame_payload); else passed++;
    // Short frame after a long one: stale capture bytes must read 0.
    send(8'hFE); send(8'h03); send(8'h01); send(8'h99); send(8'hEF);
    total++; if (frame_payload !== 64'h99) $display("FAIL short_after_long got %h want 99", frame_payload); else passed++;
    @(negedge clk);
  endtask

  task automatic test_resync;
    send(8'hFE); send(8'h02); send(8'h03); send(8'hFE);
    total++; if ({err_pulse, err_code} !== {1'b1, 3'd3}) $display("FAIL resync_err got %b/%0d want 1/3", err_pulse, err_code); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL resync_busy got %b want 1", busy); else passed++;
    send(8'h02); send(8'h01); send(8'hEF);
    total++; if ({frame_valid, frame_cmd} !== {1'b1, 8'h01}) $display("FAIL resync_frame got %b/%h want 1/01", frame_valid, frame_cmd); else passed++;
    send(8'hFE); send(8'h02); send(8'h03); send(8'h55);
    total++; if ({err_pulse, err_code, busy} !== {1'b1, 3'd3, 1'b0}) $display("FAIL end_err_idle got %b/%0d/%b want 1/3/0", err_pulse, err_code, busy); else passed++;
  endtask

  task automatic test_len_cmd;
    send(8'hFE); send(8'h0B);
    total++; if ({err_pulse, err_code, busy} !== {1'b1, 3'd1, 1'b0}) $display("FAIL len_big got %b/%0d/%b want 1/1/0", err_pulse, err_code, busy); else passed++;
    send(8'hFE); send(8'h01);
    total++; if ({err_pulse, err_code} !== {1'b1, 3'd1}) $display("FAIL len_small got %b/%0d want 1/1", err_pulse, err_code); else passed++;
    send(8'hFE); send(8'h02); send(8'h09);
    total++; if ({err_pulse, err_code, busy} !== {1'b1, 3'd2, 1'b0}) $display("FAIL cmd_big got %b/%0d/%b want 1/2/0", err_pulse, err_code, busy); else passed++;
    @(negedge clk);
    total++; if ({err_pulse, err_code} !== {1'b0, 3'd2}) $display("FAIL err_hold got %b/%0d want 0/2", err_pulse, err_code); else passed++;
    send(8'hFE); send(8'h02); send(8'h00);
    total++; if ({err_pulse, err_code} !== {1'b1, 3'd2}) $display("FAIL cmd_zero got %b/%0d want 1/2", err_pulse, err_code); else passed++;
  endtask

  task automatic test_timeout;
    int early;
    send(8'hFE); send(8'h03);
    early = 0;
    for (int k = 1; k < 50; k++) begin
      @(negedge clk);
      if (err_pulse || !busy) early++;
    end
    total++; if (early !== 0) $display("FAIL tmo_early got %0d want 0", early); else passed++;
    @(negedge clk);
    total++; if ({err_pulse, err_code, busy} !== {1'b1, 3'd4, 1'b0}) $display("FAIL tmo_fire got %b/%0d/%b want 1/4/0", err_pulse, err_code, busy); else passed++;
    @(negedge clk);
    total++; if (err_pulse !== 1'b0) $display("FAIL tmo_one_cycle got %b want 0", err_pulse); else passed++;
    // A byte at idle cycle 49 restarts the count.
    send(8'hFE); send(8'h03);
    early = 0;
    repeat (48) begin
      @(negedge clk);
      if (err_pulse) early++;
    end
    UART_Rx = 8'h01; Flag_Rx = 1'b1;
    @(negedge clk);
    Flag_Rx = 1'b0; UART_Rx = 8'h00;
    for (int k = 1; k < 50; k++) begin
      @(negedge clk);
      if (err_pulse || !busy) early++;
    end
    total++; if (early !== 0) $display("FAIL tmo_restart_early got %0d want 0", early); else passed++;
    @(negedge clk);
    total++; if ({err_pulse, err_code, busy} !== {1'b1, 3'd4, 1'b0}) $display("FAIL tmo_restart got %b/%0d/%b want 1/4/0", err_pulse, err_code, busy); else passed++;
  endtask

  task automatic test_back_to_back;
    int e0;
    frame_ready = 1'b0;
    send(8'hFE); send(8'h02); send(8'h01); send(8'hEF);
    total++; if ({frame_valid, frame_cmd} !== {1'b1, 8'h01}) $display("FAIL b2b_first got %b/%h want 1/01", frame_valid, frame_cmd); else passed++;
    send(8'hFE); send(8'h02); send(8'h02); send(8'hEF);
    total++; if ({err_pulse, err_code} !== {1'b1, 3'd5}) $display("FAIL b2b_ovr got %b/%0d want 1/5", err_pulse, err_code); else passed++;
    total++; if ({frame_valid, frame_cmd, frame_len} !== {1'b1, 8'h01, 4'd0}) $display("FAIL b2b_hold got %b/%h/%0d want 1/01/0", frame_valid, frame_cmd, frame_len); else passed++;
    send(8'hFE); send(8'h03); send(8'h04); send(8'h77);
    total++; if (frame_cmd !== 8'h01) $display("FAIL b2b_stall_stable got %h want 01", frame_cmd); else passed++;
    @(negedge clk);
    e0 = err_seen;
    frame_ready = 1'b1;
    send(8'hEF);
    frame_ready = 1'b0;
    total++; if ({frame_valid, frame_cmd, frame_len} !== {1'b1, 8'h04, 4'd1}) $display("FAIL b2b_third got %b/%h/%0d want 1/04/1", frame_valid, frame_cmd, frame_len); else passed++;
    total++; if (frame_payload !== 64'h77) $display("FAIL b2b_third_pay got %h want 77", frame_payload); else passed++;
    @(negedge clk);
    total++; if (err_seen !== e0) $display("FAIL b2b_no_ovr got %0d want %0d", err_seen, e0); else passed++;
  endtask

  task automatic test_reset_mid_frame;
    int e0;
    send(8'hFE); send(8'h05); send(8'h02); send(8'hAA);
    total++; if ({busy, frame_valid} !== 2'b11) $display("FAIL mid_pre got %b want 11", {busy, frame_valid}); else passed++;
    e0 = err_seen;
    #2 rst = 1'b0;
    #1;
    total++; if ({frame_valid, busy, err_pulse, err_code} !== 6'b0) $display("FAIL mid_rst_flags got %b/%b/%b/%0d want 0", frame_valid, busy, err_pulse, err_code); else passed++;
    total++; if ({frame_cmd, frame_len, frame_payload} !== '0) $display("FAIL mid_rst_data got %h/%0d/%h want 0", frame_cmd, frame_len, frame_payload); else passed++;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk);
    total++; if ({err_seen, err_pulse, busy} !== {e0, 1'b0, 1'b0}) $display("FAIL mid_no_err got %0d/%b/%b want %0d/0/0", err_seen, err_pulse, busy, e0); else passed++;
    frame_ready = 1'b1;
    send(8'hFE); send(8'h02); send(8'h05); send(8'hEF);
    total++; if ({frame_valid, frame_cmd} !== {1'b1, 8'h05}) $display("FAIL mid_recover got %b/%h want 1/05", frame_valid, frame_cmd); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_payload();
    test_resync();
    test_len_cmd();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
